// File: rtl/acc_seq_pkg.sv
// Shared definitions for the 4-bit accumulator sequencer: op encodings,
// FSM state type and saturation limits.
package acc_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    RESULT = 2'b10
  } state_e;

  localparam logic [3:0] SAT_POS = 4'b0111;
  localparam logic [3:0] SAT_NEG = 4'b1000;

endpackage

// File: rtl/acc_flag_unit.sv
// Signed-overflow detection and next-accumulator selection for ADD/SUB.
// Saturation on overflow is built only when ACC_SATURATE_EN is defined.
module acc_flag_unit
  import acc_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       sel,
  output logic       ovf,
  output logic [3:0] acc_next
);

  always_comb begin
    // SUB adds ~b, so operand signs must differ for an overflow to be possible.
    ovf = (sel ? (a[3] != b[3]) : (a[3] == b[3])) && (s[3] != a[3]);
`ifdef ACC_SATURATE_EN
    acc_next = ovf ? (a[3] ? SAT_NEG : SAT_POS) : s;
`else
    acc_next = s;
`endif
  end

endmodule

// File: rtl/acc_sequencer_4bit.sv
// Accumulator sequencer driving an external 4-bit adder_subtractor through an
// IDLE/WAIT/RESULT handshake FSM. Optional saturation: ACC_SATURATE_EN.
module acc_sequencer_4bit
  import acc_seq_pkg::*;
#(
  parameter int unsigned ADD_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [3:0] in_operand,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_sel,
  input  logic [3:0] add_s,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_acc,
  output logic       out_cout,
  output logic       out_ovf
);

  localparam logic [3:0] LAST_WAIT = 4'(ADD_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic       cout_q, cout_d;
  logic       ovf_q, ovf_d;
  logic [3:0] add_a_q, add_a_d;
  logic [3:0] add_b_q, add_b_d;
  logic       add_sel_q, add_sel_d;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic [3:0] cnt_q, cnt_d;

  logic       flag_ovf;
  logic [3:0] flag_acc;

  acc_flag_unit u_flag (
    .a        (add_a_q),
    .b        (add_b_q),
    .s        (add_s),
    .sel      (add_sel_q),
    .ovf      (flag_ovf),
    .acc_next (flag_acc)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    acc_d       = acc_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_sel_d   = add_sel_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          case (op_e'(in_op))
            OP_LOAD, OP_CLEAR: begin
              acc_d       = (op_e'(in_op) == OP_LOAD) ? in_operand : 4'b0000;
              cout_d      = 1'b0;
              ovf_d       = 1'b0;
              out_valid_d = 1'b1;
              state_d     = RESULT;
            end
            default: begin
              add_a_d   = acc_q;
              add_b_d   = in_operand;
              add_sel_d = (op_e'(in_op) == OP_SUB);
              cnt_d     = 4'd0;
              state_d   = WAIT;
            end
          endcase
        end
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          acc_d       = flag_acc;
          cout_d      = add_cout;
          ovf_d       = flag_ovf;
          out_valid_d = 1'b1;
          state_d     = RESULT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 4'b0000;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      add_a_q     <= 4'b0000;
      add_b_q     <= 4'b0000;
      add_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_sel_q   <= add_sel_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_sel   = add_sel_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_acc_sequencer_4bit.sv
// Directed bench: instance 0 uses ADD_WAIT=1, instance 1 uses ADD_WAIT=4;
// each is paired with a behavioural model of the external adder_subtractor.
module tb_acc_sequencer_4bit;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] ADD   = 2'b01;
  localparam logic [1:0] SUB   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic       clk;
  logic       rst;
  logic [1:0] in_op;
  logic [3:0] in_operand;
  logic       out_ready;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [3:0] add_a     [2];
  logic [3:0] add_b     [2];
  logic       add_sel   [2];
  logic [3:0] add_s     [2];
  logic       add_cout  [2];
  logic       out_valid [2];
  logic [3:0] out_acc   [2];
  logic       out_cout  [2];
  logic       out_ovf   [2];

  int checks = 0;
  int errors = 0;

  acc_sequencer_4bit #(.ADD_WAIT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_op(in_op), .in_operand(in_operand),
    .add_a(add_a[0]), .add_b(add_b[0]), .add_sel(add_sel[0]),
    .add_s(add_s[0]), .add_cout(add_cout[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_acc(out_acc[0]), .out_cout(out_cout[0]), .out_ovf(out_ovf[0])
  );

  acc_sequencer_4bit #(.ADD_WAIT(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_op(in_op), .in_operand(in_operand),
    .add_a(add_a[1]), .add_b(add_b[1]), .add_sel(add_sel[1]),
    .add_s(add_s[1]), .add_cout(add_cout[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_acc(out_acc[1]), .out_cout(out_cout[1]), .out_ovf(out_ovf[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_adder
    assign {add_cout[g], add_s[g]} = {1'b0, add_a[g]}
                                   + {1'b0, (add_sel[g] ? ~add_b[g] : add_b[g])}
                                   + {4'b0000, add_sel[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command, wait for its result, consume it; lat counts cycles
  // from acceptance to out_valid.
  task automatic run_cmd(input int idx, input logic [1:0] op, input logic [3:0] val,
                         output int lat, output logic [3:0] acc,
                         output logic c, output logic v);
    int n;
    @(negedge clk);
    in_op = op;
    in_operand = val;
    in_valid[idx] = 1'b1;
    n = 0;
    while (!in_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid[idx] = 1'b0;
    lat = 1;
    while (!out_valid[idx] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_valid[idx] !== 1'b1) begin
      errors++;
      $display("FAIL run_cmd_timeout dut%0d op=%b: out_valid=%b required 1", idx, op, out_valid[idx]);
    end
    acc = out_acc[idx];
    c   = out_cout[idx];
    v   = out_ovf[idx];
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({out_valid[0], out_acc[0], out_cout[0], out_ovf[0]} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b acc=%b cout=%b ovf=%b required all 0",
               out_valid[0], out_acc[0], out_cout[0], out_ovf[0]);
    end
    checks++;
    if ({add_a[0], add_b[0], add_sel[0]} !== 9'b0) begin
      errors++;
      $display("FAIL reset_adder_port: a=%b b=%b sel=%b required 0", add_a[0], add_b[0], add_sel[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1 || in_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b%b required 11", in_ready[0], in_ready[1]);
    end
  endtask

  task automatic test_add();
    int lat; logic [3:0] acc; logic c, v;
    run_cmd(0, LOAD, 4'b0011, lat, acc, c, v);
    checks++;
    if (lat !== 1 || acc !== 4'b0011 || c !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL load_0011: lat=%0d acc=%b c=%b v=%b required lat=1 acc=0011 c=0 v=0", lat, acc, c, v);
    end
    run_cmd(0, ADD, 4'b0100, lat, acc, c, v);
    checks++;
    if (lat !== 2 || acc !== 4'b0111 || c !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL add_0100: lat=%0d acc=%b c=%b v=%b required lat=2 acc=0111 c=0 v=0", lat, acc, c, v);
    end
    checks++;
    if (add_a[0] !== 4'b0011 || add_b[0] !== 4'b0100 || add_sel[0] !== 1'b0) begin
      errors++;
      $display("FAIL add_port_hold: a=%b b=%b sel=%b required 0011 0100 0", add_a[0], add_b[0], add_sel[0]);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [3:0] acc; logic c, v;
    logic [3:0] exp_acc;
`ifdef ACC_SATURATE_EN
    exp_acc = 4'b0111;
`else
    exp_acc = 4'b1000;
`endif
    run_cmd(0, LOAD, 4'b0111, lat, acc, c, v);
    run_cmd(0, ADD, 4'b0001, lat, acc, c, v);
    checks++;
    if (acc !== exp_acc || c !== 1'b0 || v !== 1'b1) begin
      errors++;
      $display("FAIL add_overflow: acc=%b c=%b v=%b required acc=%b c=0 v=1", acc, c, v, exp_acc);
    end
  endtask

  task automatic test_sub();
    int lat; logic [3:0] acc; logic c, v;
    logic [3:0] exp_acc;
`ifdef ACC_SATURATE_EN
    exp_acc = 4'b1000;
`else
    exp_acc = 4'b0011;
`endif
    run_cmd(0, LOAD, 4'b1101, lat, acc, c, v);
    run_cmd(0, SUB, 4'b1111, lat, acc, c, v);
    checks++;
    if (lat !== 2 || acc !== 4'b1110 || c !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL sub_1111: lat=%0d acc=%b c=%b v=%b required lat=2 acc=1110 c=0 v=0", lat, acc, c, v);
    end
    checks++;
    if (add_sel[0] !== 1'b1) begin
      errors++;
      $display("FAIL sub_sel: add_sel=%b required 1", add_sel[0]);
    end
    run_cmd(0, LOAD, 4'b1000, lat, acc, c, v);
    run_cmd(0, SUB, 4'b0101, lat, acc, c, v);
    checks++;
    if (acc !== exp_acc || c !== 1'b1 || v !== 1'b1) begin
      errors++;
      $display("FAIL sub_overflow: acc=%b c=%b v=%b required acc=%b c=1 v=1", acc, c, v, exp_acc);
    end
    run_cmd(0, CLEAR, 4'b1111, lat, acc, c, v);
    checks++;
    if (lat !== 1 || acc !== 4'b0000 || c !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL clear: lat=%0d acc=%b c=%b v=%b required lat=1 acc=0000 c=0 v=0", lat, acc, c, v);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_op = LOAD;
    in_operand = 4'b1010;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_op = CLEAR;
    in_operand = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid[0] !== 1'b1 || out_acc[0] !== 4'b1010 || out_cout[0] !== 1'b0 ||
          out_ovf[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b acc=%b c=%b v=%b in_ready=%b required 1 1010 0 0 0",
                 i, out_valid[0], out_acc[0], out_cout[0], out_ovf[0], in_ready[0]);
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_acc[0] !== 4'b1010) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b valid=%b acc=%b required 1 0 1010",
               in_ready[0], out_valid[0], out_acc[0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [3:0] acc; logic c, v;
    run_cmd(1, LOAD, 4'b0010, lat, acc, c, v);
    run_cmd(1, ADD, 4'b0100, lat, acc, c, v);
    checks++;
    if (lat !== 5 || acc !== 4'b0110 || c !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL wait4_add: lat=%0d acc=%b c=%b v=%b required lat=5 acc=0110 c=0 v=0", lat, acc, c, v);
    end
    @(negedge clk);
    in_op = ADD;
    in_operand = 4'b0001;
    in_valid[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b0 || add_a[1] !== 4'b0110 || add_b[1] !== 4'b0001) begin
      errors++;
      $display("FAIL wait4_in_wait: valid=%b in_ready=%b a=%b b=%b required 0 0 0110 0001",
               out_valid[1], in_ready[1], add_a[1], add_b[1]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid[1] !== 1'b0 || out_acc[1] !== 4'b0000 || out_cout[1] !== 1'b0 || out_ovf[1] !== 1'b0 ||
        add_a[1] !== 4'b0000 || add_b[1] !== 4'b0000 || add_sel[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait_reset: valid=%b acc=%b c=%b v=%b a=%b b=%b sel=%b rdy=%b required 0 0000 0 0 0000 0000 0 1",
               out_valid[1], out_acc[1], out_cout[1], out_ovf[1], add_a[1], add_b[1], add_sel[1], in_ready[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    run_cmd(1, LOAD, 4'b0101, lat, acc, c, v);
    checks++;
    if (lat !== 1 || acc !== 4'b0101) begin
      errors++;
      $display("FAIL post_reset_load: lat=%0d acc=%b required lat=1 acc=0101", lat, acc);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_op = LOAD;
    in_operand = 4'b0000;
    out_ready = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_backpressure();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acc_sequencer_4bit.md
ACC_SEQUENCER_4BIT -- requirements
Module: acc_sequencer_4bit

Interface
REQ-001 SHALL have parameter ADD_WAIT, default 1, meaning the number of cycles operands are held on the adder port before the result is captured (range 1-15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, command present.
REQ-005 SHALL have port in_ready, output, 1, block can accept a command.
REQ-006 SHALL have port in_op, input, 2, command: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-007 SHALL have port in_operand, input, 4, operand B, or load value.
REQ-008 SHALL have port add_a, output, 4, operand A to the external 4-bit adder_subtractor.
REQ-009 SHALL have port add_b, output, 4, operand B to the external adder_subtractor.
REQ-010 SHALL have port add_sel, output, 1, adder mode: 0 = A+B, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have port add_s, input, 4, sum from the adder.
REQ-012 SHALL have port add_cout, input, 1, carry from the adder; for SUB, 1 means no borrow.
REQ-013 SHALL have port out_valid, output, 1, result available.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-015 SHALL have ports out_acc (output, 4, accumulator value), out_cout (output, 1, captured carry), and out_ovf (output, 1, signed two's-complement overflow).

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT, and RESULT; in_ready SHALL be 1 only in IDLE.
REQ-017 A command SHALL be accepted on a cycle where in_valid and in_ready are both 1; op and operand SHALL be latched on acceptance.
REQ-018 On accepting LOAD or CLEAR, the block SHALL set acc to in_operand (LOAD) or 0000 (CLEAR), clear cout and ovf to 0, and move IDLE->RESULT; out_valid SHALL rise 1 cycle after acceptance.
REQ-019 On accepting ADD or SUB, the block SHALL register add_a=acc, add_b=in_operand, and add_sel=(op==SUB), then move IDLE->WAIT.
REQ-020 While in WAIT, add_a, add_b, and add_sel SHALL be stable; after ADD_WAIT cycles the block SHALL capture add_s into acc and add_cout into cout, compute ovf, and move to RESULT; out_valid SHALL rise 1+ADD_WAIT cycles after acceptance.
REQ-021 Overflow SHALL be computed as follows: ADD: a[3]==b[3] and s[3]!=a[3]; SUB: a[3]!=b[3] and s[3]!=a[3].
REQ-022 In RESULT, out_valid SHALL be 1; out_acc, out_cout, and out_ovf SHALL hold stable until out_valid and out_ready are both 1, after which the block SHALL return to IDLE on the next cycle.
REQ-023 A command presented while the block is not in IDLE SHALL be ignored and not latched; the upstream holds it until in_ready is 1.
REQ-024 In IDLE and RESULT, add_a, add_b, and add_sel SHALL hold their last-driven values.
REQ-025 Arithmetic SHALL wrap modulo 16 unless ACC_SATURATE_EN is defined.

Reset
REQ-026 Assertion of rst SHALL, at any time including mid-WAIT, force the state to IDLE, acc=0000, cout=0, ovf=0, add_a=0000, add_b=0000, add_sel=0, out_valid=0, and wait counter=0.
REQ-027 in_ready SHALL be 1 on the first clock edge after rst deasserts.

Configuration
REQ-028 When macro ACC_SATURATE_EN is defined, an ADD/SUB result with ovf=1 SHALL load acc with 0111 if a[3]==0 and 1000 if a[3]==1, and out_ovf SHALL still be 1.
REQ-029 When ACC_SATURATE_EN is undefined, acc SHALL take add_s unmodified, and no saturation logic SHALL be present.

Structure
REQ-030 Package acc_seq_pkg SHALL hold the op encodings (OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR), the FSM state type, and the constants SAT_POS=0111 and SAT_NEG=1000.
REQ-031 Sub-module acc_flag_unit SHALL compute ovf and the saturated or wrapped next-acc value from a, b, s, and sel; the external adder SHALL NOT be instantiated inside this block.

Verification
REQ-032 Test: LOAD 0011, then ADD 0100 with ADD_WAIT=1 -> out_acc=0111, out_cout=0, out_ovf=0; out_valid rises 2 cycles after ADD acceptance.
REQ-033 Test: LOAD 0111, then ADD 0001 -> out_ovf=1; out_acc=1000 without the macro, 0111 with ACC_SATURATE_EN.
REQ-034 Test: LOAD 1101, then SUB 1111 -> out_acc=1110, out_cout=0, out_ovf=0; LOAD 1000, then SUB 0101 -> out_cout=1, out_ovf=1, and out_acc=0011 (wrap) or 1000 (saturate).
REQ-035 Test: hold out_ready=0 for 5 cycles after a result -> out_* remain stable, in_ready=0, and a command presented meanwhile is not accepted.
REQ-036 Test: assert rst mid-WAIT with ADD_WAIT=4 -> all outputs go to their reset values immediately, and the next LOAD 0101 returns out_acc=0101.
